// File: rtl/stage3_writeback_if.sv
// stage3_writeback_if: data-memory req/ready/rvalid handshake between stage 3 and memory.
interface stage3_writeback_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   modport master (output req, we, addr, wdata, wmask, input ready, rvalid, rdata);
   modport slave (input req, we, addr, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/stage3_writeback.sv
// stage3_writeback: RV32I stage 3 - memory access, load alignment, write-back and forwarding selects.
module stage3_writeback #(
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                stage2_inst_in,
   input  logic [31:0]                stage2_pc_in,
   input  logic [31:0]                stage2_alu_in,
   input  logic [31:0]                stage2_rs2_in,
   output logic [31:0]                stage3_inst,
   output logic                       wb_en,
   output logic [4:0]                 wb_rd,
   output logic [31:0]                wb_data,
   output logic                       rs1_data_sel,
   output logic                       rs2_data_sel,
   output logic                       stall,
   output logic                       misalign_err,
   stage3_writeback_if.master         dmem
);
   typedef enum logic {RUN, LWAIT} state_t;
   state_t      state_q, state_d;
   logic [31:0] inst_q, pc_q, alu_q, rs2_q;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [1:0]  sel;
   logic        is_load, is_store, is_jump, writes_rd, misaligned, mem_op;
   logic [7:0]  lbyte;
   logic [15:0] lhalf;
   logic [31:0] ldata;
   assign opc        = inst_q[6:0];
   assign f3         = inst_q[14:12];
   assign sel        = alu_q[1:0];
   assign is_load    = opc == 7'b0000011;
   assign is_store   = opc == 7'b0100011;
   assign is_jump    = opc == 7'b1101111 || opc == 7'b1100111;
   assign writes_rd  = is_load || is_jump || opc == 7'b0110011 || opc == 7'b0010011 ||
                       opc == 7'b0110111 || opc == 7'b0010111;
   assign misaligned = (is_load || is_store) &&
                       ((f3[1:0] == 2'b01 && sel[0]) || (f3[1:0] == 2'b10 && sel != 2'b00));
   assign mem_op     = (is_load || is_store) && !misaligned;
   assign lbyte      = dmem.rdata[{sel, 3'b000} +: 8];
   assign lhalf      = sel[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
   assign ldata      = f3[1:0] == 2'b00 ? {{24{lbyte[7] & ~f3[2]}}, lbyte} :
                       f3[1:0] == 2'b01 ? {{16{lhalf[15] & ~f3[2]}}, lhalf} : dmem.rdata;
   // A load holds the pipe from request until its data returns; a store only until accepted.
   always_comb begin
      state_d  = state_q;
      dmem.req = 1'b0;
      stall    = 1'b0;
      if (state_q == RUN) begin
         dmem.req = mem_op;
         stall    = mem_op && (is_load || !dmem.ready);
         if (mem_op && is_load && dmem.ready) state_d = LWAIT;
      end else begin
         stall = !dmem.rvalid;
         if (dmem.rvalid) state_d = RUN;
      end
   end
   assign dmem.we      = dmem.req && is_store;
   assign dmem.addr    = {alu_q[31:2], 2'b00};
   assign dmem.wdata   = !is_store ? 32'd0 :
                         f3[1:0] == 2'b00 ? {4{rs2_q[7:0]}} :
                         f3[1:0] == 2'b01 ? {2{rs2_q[15:0]}} : rs2_q;
   assign dmem.wmask   = !is_store ? 4'b0000 :
                         f3[1:0] == 2'b00 ? 4'b0001 << sel :
                         f3[1:0] == 2'b01 ? 4'b0011 << sel : 4'b1111;
   assign stage3_inst  = inst_q;
   assign wb_rd        = inst_q[11:7];
   assign wb_en        = writes_rd && wb_rd != 5'd0 && !stall && !misaligned;
   assign wb_data      = is_jump ? pc_q + 32'd4 : is_load ? ldata : alu_q;
   assign misalign_err = misaligned;
   assign rs1_data_sel = wb_en && wb_rd == stage2_inst_in[19:15];
   assign rs2_data_sel = wb_en && wb_rd == stage2_inst_in[24:20];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         inst_q  <= NOP_INST;
         pc_q    <= 32'd0;
         alu_q   <= 32'd0;
         rs2_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         if (!stall) begin
            inst_q <= stage2_inst_in;
            pc_q   <= stage2_pc_in;
            alu_q  <= stage2_alu_in;
            rs2_q  <= stage2_rs2_in;
         end
      end
   end
endmodule

// File: tb/tb_stage3_writeback.sv
// tb_stage3_writeback: directed and randomized checks of stage 3 against a byte-level memory/write-back model.
module tb_stage3_writeback;
   localparam logic [31:0] NOP = 32'h00000013;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s2_inst = NOP, s2_pc = '0, s2_alu = '0, s2_rs2 = '0;
   logic [31:0] stage3_inst, wb_data;
   logic        wb_en, rs1_data_sel, rs2_data_sel, stall, misalign_err;
   logic [4:0]  wb_rd;
   int          checks = 0, errors = 0, stall_cycles, req_cycles;
   logic [31:0] last_wb, last_wdata;
   logic [3:0]  last_mask;
   stage3_writeback_if dmem ();
   stage3_writeback dut (
      .clk(clk), .rst_n(rst_n),
      .stage2_inst_in(s2_inst), .stage2_pc_in(s2_pc), .stage2_alu_in(s2_alu), .stage2_rs2_in(s2_rs2),
      .stage3_inst(stage3_inst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .rs1_data_sel(rs1_data_sel), .rs2_data_sel(rs2_data_sel), .stall(stall),
      .misalign_err(misalign_err), .dmem(dmem)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, f3, rd, opc};
   endfunction

   // Load result: pick the addressed bytes, then extend from the access size.
   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      int n;
      logic [31:0] v, m;
      n = 1 << f3[1:0];
      if (n == 4) return w;
      m = (32'd1 << (8 * n)) - 32'd1;
      v = (w >> (8 * off)) & m;
      if (!f3[2] && v[8 * n - 1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [3:0] mask_model(input logic [2:0] f3, input logic [1:0] off);
      int n;
      n = 1 << f3[1:0];
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] wdata_model(input logic [31:0] d, input logic [2:0] f3);
      int n;
      logic [31:0] r;
      n = 1 << f3[1:0];
      for (int i = 0; i < 4; i++) r[8 * i +: 8] = d[8 * (i % n) +: 8];
      return r;
   endfunction

   task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2);
      s2_inst = inst; s2_pc = pc; s2_alu = alu; s2_rs2 = rs2;
      @(negedge clk);
      s2_inst = NOP; s2_pc = '0; s2_alu = '0; s2_rs2 = '0;
   endtask

   task automatic run_mem(input logic ld, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int rdly, input int vdly);
      int n;
      n = 1 << f3[1:0];
      stall_cycles = 0;
      req_cycles = 0;
      dmem.rdata = rdata;
      issue(enc(ld ? 7'b0000011 : 7'b0100011, f3, rd, 5'd1, 5'd2), 32'h40, alu, rs2);
      if (int'(alu[1:0]) % n != 0) begin
         #1;
         chk("mis_err", 32'(misalign_err), 32'd1);
         chk("mis_req", 32'(dmem.req), 32'd0);
         chk("mis_stall", 32'(stall), 32'd0);
         chk("mis_wben", 32'(wb_en), 32'd0);
         @(negedge clk);
         #1 chk("mis_pulse", 32'(misalign_err), 32'd0);
         return;
      end
      for (int c = 0; c <= rdly; c++) begin
         dmem.ready = (c == rdly);
         #1;
         chk("req", 32'(dmem.req), 32'd1);
         chk("we", 32'(dmem.we), 32'(!ld));
         chk("addr", dmem.addr, alu & 32'hFFFF_FFFC);
         chk("wmask", 32'(dmem.wmask), ld ? 32'd0 : 32'(mask_model(f3, alu[1:0])));
         if (!ld) chk("wdata", dmem.wdata, wdata_model(rs2, f3));
         chk("req_stall", 32'(stall), 32'(ld || c != rdly));
         chk("req_wben", 32'(wb_en), 32'd0);
         last_mask = dmem.wmask;
         last_wdata = dmem.wdata;
         stall_cycles += int'(stall);
         req_cycles += int'(dmem.req);
         @(negedge clk);
      end
      dmem.ready = 1'b0;
      if (ld) begin
         for (int c = 1; c <= vdly; c++) begin
            dmem.rvalid = (c == vdly);
            #1;
            chk("wait_req", 32'(dmem.req), 32'd0);
            chk("wait_stall", 32'(stall), 32'(c != vdly));
            if (c == vdly) begin
               chk("ld_wben", 32'(wb_en), 32'(rd != 5'd0));
               chk("ld_data", wb_data, ld_model(rdata, f3, alu[1:0]));
               last_wb = wb_data;
            end
            stall_cycles += int'(stall);
            @(negedge clk);
         end
         dmem.rvalid = 1'b0;
      end
      #1 chk("mem_done", stage3_inst, NOP);
   endtask

   initial begin
      logic [31:0] alu, inst;
      logic [4:0]  rd, r1, r2;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        ld;
      dmem.ready = 1'b0;
      dmem.rvalid = 1'b0;
      dmem.rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_inst", stage3_inst, NOP);
      chk("rst_wben", 32'(wb_en), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(dmem.req), 32'd0);
      chk("rst_mis", 32'(misalign_err), 32'd0);
      chk("rst_data", wb_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk("idle_inst", stage3_inst, NOP);
      chk("idle_stall", 32'(stall), 32'd0);

      issue({12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011}, 32'h10, 32'd7, 32'd0);
      s2_inst = enc(7'b0110011, 3'b000, 5'd6, 5'd5, 5'd5);
      #1;
      chk("addi_wben", 32'(wb_en), 32'd1);
      chk("addi_rd", 32'(wb_rd), 32'd5);
      chk("addi_data", wb_data, 32'd7);
      chk("fwd_rs1", 32'(rs1_data_sel), 32'd1);
      chk("fwd_rs2", 32'(rs2_data_sel), 32'd1);
      issue({12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011}, 32'h14, 32'd7, 32'd0);
      s2_inst = enc(7'b0110011, 3'b000, 5'd6, 5'd0, 5'd0);
      #1;
      chk("x0_wben", 32'(wb_en), 32'd0);
      chk("x0_fwd1", 32'(rs1_data_sel), 32'd0);
      chk("x0_fwd2", 32'(rs2_data_sel), 32'd0);

      run_mem(1'b1, 3'b000, 5'd7, 32'h1003, 32'd0, 32'h80FFEE11, 0, 3);
      chk("lb_data_c", last_wb, 32'hFFFFFF80);
      chk("lb_stall_n", 32'(stall_cycles), 32'd3);
      run_mem(1'b1, 3'b100, 5'd7, 32'h1003, 32'd0, 32'h80FFEE11, 0, 3);
      chk("lbu_data_c", last_wb, 32'h00000080);
      run_mem(1'b0, 3'b001, 5'd0, 32'h2002, 32'h0000BEEF, 32'd0, 2, 0);
      chk("sh_req_n", 32'(req_cycles), 32'd3);
      chk("sh_stall_n", 32'(stall_cycles), 32'd2);
      chk("sh_mask_c", 32'(last_mask), 32'b1100);
      chk("sh_wdata_c", last_wdata, 32'hBEEFBEEF);
      run_mem(1'b1, 3'b010, 5'd9, 32'h3001, 32'd0, 32'd0, 0, 1);

      issue(enc(7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0), 32'h100, 32'h0, 32'd0);
      #1;
      chk("jal_data", wb_data, 32'h104);
      chk("jal_wben", 32'(wb_en), 32'd1);
      dmem.rdata = 32'h12345678;
      issue(enc(7'b0000011, 3'b010, 5'd3, 5'd1, 5'd0), 32'h104, 32'h3000, 32'd0);
      dmem.ready = 1'b1;
      #1 chk("rl_req", 32'(dmem.req), 32'd1);
      @(negedge clk);
      dmem.ready = 1'b0;
      #1 chk("rl_wait", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rl_req0", 32'(dmem.req), 32'd0);
      chk("rl_stall0", 32'(stall), 32'd0);
      chk("rl_inst", stage3_inst, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      dmem.rvalid = 1'b1;
      #1;
      chk("stray_wben", 32'(wb_en), 32'd0);
      chk("stray_stall", 32'(stall), 32'd0);
      @(negedge clk);
      dmem.rvalid = 1'b0;

      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               opc = $urandom_range(0, 3) == 0 ? 7'b0110111 : $urandom_range(0, 1) ? 7'b0010011 : 7'b0110011;
               rd = 5'($urandom_range(0, 31));
               alu = $urandom;
               issue(enc(opc, 3'b000, rd, 5'd2, 5'd3), 32'h200, alu, 32'd0);
               r1 = $urandom_range(0, 1) ? rd : 5'($urandom_range(0, 31));
               r2 = $urandom_range(0, 1) ? rd : 5'($urandom_range(0, 31));
               s2_inst = enc(7'b0110011, 3'b000, 5'd9, r1, r2);
               #1;
               chk("r_alu_wben", 32'(wb_en), 32'(rd != 5'd0));
               chk("r_alu_data", wb_data, alu);
               chk("r_fwd1", 32'(rs1_data_sel), 32'(rd != 5'd0 && r1 == rd));
               chk("r_fwd2", 32'(rs2_data_sel), 32'(rd != 5'd0 && r2 == rd));
            end
            1, 2: begin
               ld = $urandom_range(0, 1);
               f3 = ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
               if (ld && f3 == 3'd3) f3 = 3'd5;
               run_mem(ld, f3, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 2), $urandom_range(1, 3));
            end
            default: begin
               inst = enc($urandom_range(0, 1) ? 7'b1101111 : 7'b1100111, 3'b000, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
               alu = $urandom & 32'hFFFF_FFFC;
               issue(inst, alu, $urandom, 32'd0);
               #1;
               chk("r_jmp_wben", 32'(wb_en), 32'd1);
               chk("r_jmp_data", wb_data, alu + 32'd4);
            end
         endcase
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
